// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the instruction-memory port, the consumer handshake
// and the fetch-control inputs of the fetch front end.
//   master : the fetch front end (drives readM1/address1 and the FIFO head)
//   slave  : memory + controller side (drives data1, inst_ready, redirect, halt)
interface fetch_queue_if #(
    parameter int unsigned WORD_SIZE = 16
);
    logic                 readM1;
    logic [WORD_SIZE-1:0] address1;
    logic [WORD_SIZE-1:0] data1;
    logic                 inst_valid;
    logic [WORD_SIZE-1:0] inst;
    logic [WORD_SIZE-1:0] inst_pc;
    logic                 inst_ready;
    logic                 redirect;
    logic [WORD_SIZE-1:0] redirect_pc;
    logic                 halt;
    logic [WORD_SIZE-1:0] fetch_count;
    logic                 is_halted;

    modport master (
        output readM1, address1, inst_valid, inst, inst_pc, fetch_count, is_halted,
        input  data1, inst_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  readM1, address1, inst_valid, inst, inst_pc, fetch_count, is_halted,
        output data1, inst_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: pipelined instruction fetch with a fixed-latency memory, a
// DEPTH-entry return FIFO, redirect flush, sticky halt and a pop counter.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : fetch_queue_if.master (memory port, consumer handshake, control)
module fetch_queue #(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    fetch_queue_if.master  bus
);
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned CREDIT_W = $clog2(DEPTH + MEM_LATENCY + 1);

    logic [WORD_SIZE-1:0]   fetchPc;
    logic [WORD_SIZE-1:0]   memData [DEPTH];
    logic [WORD_SIZE-1:0]   memPc   [DEPTH];
    logic [PTR_W-1:0]       rdPtr;
    logic [PTR_W-1:0]       wrPtr;
    logic [CNT_W-1:0]       count;
    logic [MEM_LATENCY-1:0] pipeValid;
    logic [WORD_SIZE-1:0]   pipePc  [MEM_LATENCY];
    logic [WORD_SIZE-1:0]   fetchCount;
    logic                   isHalted;

    logic [CREDIT_W-1:0]    inflight;
    logic [CREDIT_W-1:0]    occupancy;
    logic                   reqC;
    logic                   headValidC;
    logic                   popC;
    logic                   pushC;

    // Credit: queued entries plus every tracked request must fit in the FIFO,
    // so a return can always be written without a full check.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(MEM_LATENCY); i++) begin
            inflight = inflight + CREDIT_W'(pipeValid[i]);
        end
        occupancy  = CREDIT_W'(count) + inflight;
        reqC       = !isHalted && (occupancy < CREDIT_W'(DEPTH));
        headValidC = (count != '0);
        popC       = headValidC && bus.inst_ready;
        pushC      = pipeValid[MEM_LATENCY-1] && !bus.redirect;
    end

    assign bus.readM1      = reqC && !reset;
    assign bus.address1    = fetchPc;
    assign bus.inst_valid  = headValidC && !reset;
    assign bus.inst        = bus.inst_valid ? memData[rdPtr] : '0;
    assign bus.inst_pc     = bus.inst_valid ? memPc[rdPtr]   : '0;
    assign bus.fetch_count = fetchCount;
    assign bus.is_halted   = isHalted;

    // Control state; redirect wins over everything except reset, but a
    // same-cycle pop is still counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetchPc    <= '0;
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            pipeValid  <= '0;
            fetchCount <= '0;
            isHalted   <= 1'b0;
        end else begin
            if (popC) begin
                fetchCount <= fetchCount + WORD_SIZE'(1);
            end
            if (bus.halt) begin
                isHalted <= 1'b1;
            end
            if (bus.redirect) begin
                fetchPc   <= bus.redirect_pc;
                rdPtr     <= '0;
                wrPtr     <= '0;
                count     <= '0;
                pipeValid <= '0;
            end else begin
                if (reqC) begin
                    fetchPc <= fetchPc + WORD_SIZE'(1);
                end
                pipeValid[0] <= reqC;
                for (int i = 1; i < int'(MEM_LATENCY); i++) begin
                    pipeValid[i] <= pipeValid[i-1];
                end
                if (pushC) begin
                    wrPtr <= wrPtr + PTR_W'(1);
                end
                if (popC) begin
                    rdPtr <= rdPtr + PTR_W'(1);
                end
                count <= count + CNT_W'(pushC) - CNT_W'(popC);
            end
        end
    end

    // Datapath storage; only meaningful where the matching valid/count says so.
    always_ff @(posedge clk) begin
        pipePc[0] <= fetchPc;
        for (int i = 1; i < int'(MEM_LATENCY); i++) begin
            pipePc[i] <= pipePc[i-1];
        end
        if (pushC && !reset) begin
            memData[wrPtr] <= bus.data1;
            memPc[wrPtr]   <= pipePc[MEM_LATENCY-1];
        end
    end
endmodule
